// File: rtl/fetch_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_pkg : shared types and helpers for the halfword fetch unit   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

   localparam int DEFAULT_QDEPTH = 4;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   // Top five bits 11101/11110/11111 mark a 32-bit encoding; masking and a
   // magnitude compare expresses exactly that set.
   function automatic logic is32_prefix(input logic [15:0] hw);
      return (hw & 16'hF800) >= 16'hE800;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_hw_queue.sv
// +--------------------------------------------------------------------+
// | hw_queue : circular halfword FIFO, 1 push, 0/1/2 pop, flush        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hw_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = DEFAULT_QDEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic [15:0]                  push_data_i,
   input  logic [1:0]                   pop_n_i,
   input  logic                         flush_i,
   output logic [15:0]                  head0_o,
   output logic [15:0]                  head1_o,
   output logic [$clog2(QDEPTH+1)-1:0]  count_o
);

   localparam int CW = $clog2(QDEPTH+1);
   localparam int PW = $clog2(QDEPTH);

   logic [15:0]   mem_q [QDEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Pointer advance that also works for non power-of-two depths.
   function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input int n);
      int s;
      s = int'(p) + n;
      if (s >= QDEPTH) s = s - QDEPTH;
      return PW'(s);
   endfunction

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         rd_ptr_d = adv(rd_ptr_q, int'(pop_n_i));
         if (push_i) wr_ptr_d = adv(wr_ptr_q, 1);
         count_d = count_q + CW'(push_i) - CW'(pop_n_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head0_o = mem_q[rd_ptr_q];
   assign head1_o = mem_q[adv(rd_ptr_q, 1)];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// +--------------------------------------------------------------------+
// | fetch_ctrl : halfword fetch sequencer feeding 16/32-bit decode     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                QDEPTH   = DEFAULT_QDEPTH
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [15:0]       imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic              inst_is32,
   output logic [ADDR_W-1:0] inst_pc
);

   localparam int                CW        = $clog2(QDEPTH+1);
   localparam logic [ADDR_W-1:0] PC_ALIGN  = ~ADDR_W'(1);
   localparam logic [ADDR_W-1:0] START_PC  = RESET_PC & PC_ALIGN;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] head_pc_q, head_pc_d;
   // Outstanding requests; while draining every one of them is stale, so
   // the same counter serves as the discard count.
   logic [CW-1:0]     out_cnt_q, out_cnt_d;

   logic [15:0]       head0, head1;
   logic [CW-1:0]     q_count;
   logic [CW:0]       credit_used;
   logic              issue;
   logic              head_is32;
   logic              push;
   logic              pop;
   logic [1:0]        pop_n;
   logic [ADDR_W-1:0] new_pc;

   hw_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (imem_rdata),
      .pop_n_i     (pop_n),
      .flush_i     (redirect),
      .head0_o     (head0),
      .head1_o     (head1),
      .count_o     (q_count)
   );

   assign new_pc      = redirect_pc & PC_ALIGN;
   assign credit_used = (CW+1)'(q_count) + (CW+1)'(out_cnt_q);
   assign imem_req    = (state_q == ST_RUN) && (credit_used < (CW+1)'(QDEPTH));
   assign imem_addr   = fetch_pc_q;
   assign issue       = imem_req & imem_gnt;

   assign head_is32   = is32_prefix(head0);
   assign inst_valid  = !redirect &&
                        (head_is32 ? (q_count >= CW'(2)) : (q_count != '0));
   assign pop         = inst_valid & inst_ready;
   assign pop_n       = pop ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
   assign push        = imem_rvalid && (state_q == ST_RUN) && !redirect;

   assign inst        = head_is32 ? {head0, head1} : {16'h0000, head0};
   assign inst_is32   = head_is32;
   assign inst_pc     = head_pc_q;

   assign out_cnt_d   = out_cnt_q + CW'(issue) - CW'(imem_rvalid);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      head_pc_d  = head_pc_q;
      case (state_q)
         ST_RESET: state_d = ST_RUN;
         ST_RUN:   if (redirect && out_cnt_d != '0) state_d = ST_DRAIN;
         ST_DRAIN: if (out_cnt_d == '0) state_d = ST_RUN;
         default:  state_d = ST_RESET;
      endcase
      if (redirect) begin
         fetch_pc_d = new_pc;
         head_pc_d  = new_pc;
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(2);
         if (pop)   head_pc_d  = head_pc_q + (head_is32 ? ADDR_W'(4) : ADDR_W'(2));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RESET;
         fetch_pc_q <= START_PC;
         head_pc_q  <= START_PC;
         out_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         head_pc_q  <= head_pc_d;
         out_cnt_q  <= out_cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Halfword fetch controller that sequences instruction-memory reads and feeds assembled 16/32-bit instructions to decode. It owns the fetch PC, keeps up to QDEPTH halfword requests in flight or buffered, and detects 32-bit encodings from the first halfword. It pairs halfwords, handles branch redirects by flushing and discarding stale responses, and presents one instruction per cycle over a valid/ready handshake.

## Interface
- ADDR_W, 32, address width
- RESET_PC, 32'h0000_0000, first fetch address after reset (bit0 forced 0)
- QDEPTH, 4, halfword queue depth; also the limit on queued plus outstanding requests (≥2)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  halfword read request
- imem_addr  out  ADDR_W  request address, bit0 always 0
- imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt = issue)
- imem_rvalid  in  1  response valid; in order, one per issue, earliest the cycle after issue
- imem_rdata  in  16  response halfword
- redirect  in  1  branch redirect, single-cycle pulse
- redirect_pc  in  ADDR_W  new fetch PC (bit0 ignored)
- inst_valid  out  1  instruction available
- inst_ready  in  1  decode accepts (transfer = inst_valid & inst_ready)
- inst  out  32  16-bit: {16'h0, hw0}; 32-bit: {hw0, hw1}, where hw0 is the first-fetched halfword
- inst_is32  out  1  instruction is 32-bit
- inst_pc  out  ADDR_W  address of hw0

## Operation
- 32-bit prefix: hw[15:13]==3'b111 && hw[12:11]!=2'b00; all other halfwords are 16-bit.
- Credit: `cnt = queue_entries + outstanding`; imem_req=1 iff state RUN and cnt<QDEPTH. imem_addr advances by 2 on each issue.
- A response pushes imem_rdata into the queue, unless discarded (see DRAIN).
- Head-of-queue decode: if hw0 is 16-bit and entries≥1, inst_valid=1. If hw0 is a 32-bit prefix, inst_valid=1 only when entries≥2. Transfer pops 1 or 2 entries; head_pc += 2 or 4.
- Push and pop in the same cycle are legal, including push with a 2-entry pop.
- States:
  - RESET: entered during rst, left on the first clk edge after release.
  - RUN: normal operation.
  - DRAIN: entered on redirect while outstanding≠0 (excluding a response returning that same cycle, which is also discarded). No requests are issued and every response is discarded with discard_cnt--. At discard_cnt==0, go to RUN.
  - On redirect with nothing outstanding, stay in RUN.
- Redirect has priority over all same-cycle events:
  - queue flushed;
  - imem_addr and head_pc load {redirect_pc[ADDR_W-1:1],1'b0};
  - inst_valid forced 0 combinationally that cycle, so no transfer occurs;
  - an issue in the same cycle counts as stale.
- A redirect during DRAIN reloads the PC. discard_cnt keeps its current value plus any issue made that cycle (none are made in DRAIN).
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_is32=0, inst_pc=RESET_PC, queue empty, counters 0, state RESET.
- Counter widths are $clog2(QDEPTH+1). Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- First imem_req is in the first cycle after reset release.
- Response in cycle N makes inst_valid=1 in cycle N+1 (registered queue) for a 16-bit instruction or for the second half of a 32-bit one.
- Throughput: one instruction per cycle when the queue holds enough halfwords.
- Request back-pressure:
  - With an empty queue and 1-cycle memory, QDEPTH=4 sustains one issue per cycle.
  - imem_req holds, with imem_addr stable, until imem_gnt.
- Redirect in cycle R: first new imem_req in R+1 if nothing was stale; otherwise in the cycle after the last stale response.
- inst, inst_is32 and inst_pc stay stable while inst_valid & !inst_ready, except across a redirect.

## Structure
- Package fetch_pkg holds:
  - function is32_prefix(hw);
  - state encoding RESET/RUN/DRAIN;
  - default QDEPTH.
- Sub-module hw_queue: QDEPTH×16 circular FIFO with 1 push, 0/1/2 pop, flush, and exposes head0/head1/count.
- fetch_ctrl holds the FSM, credit counter, discard counter, fetch PC and head_pc.

## Test plan
- Reset with RESET_PC=0x100, 1-cycle memory returning 0x4600 repeatedly, inst_ready=1 → requests to 0x100, 0x102, …; inst=0x0000_4600 with inst_pc 0x100, 0x102, … at one per cycle.
- Halfwords 0xF000, 0x8000 at 0x200 → single transfer, inst=0xF000_8000, inst_is32=1, inst_pc=0x200. The next instruction has inst_pc 0x204.
- 0xE7FE (prefix bits 12:11 = 00) → treated as 16-bit, inst_is32=0.
- inst_ready=0 for 10 cycles → imem_req drops once cnt reaches 4 and inst holds stable. inst_ready=1 → requests resume.
- 3-cycle memory latency with 3 requests outstanding, redirect to 0x401 → DRAIN for the 3 stale responses with nothing pushed. The first new request is to 0x400 and the next inst_pc is 0x400.
- Redirect in the same cycle as inst_valid & inst_ready and an arriving response → no transfer, response discarded, queue empty the next cycle.
